// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Optional build macro used by the unit: MDU_EARLY_OUT_EN.
package mdu_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    FIXUP = 2'b10,
    DONE  = 2'b11
  } mdu_state_t;

  function automatic logic op_is_div(mdu_op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// 2*XLEN accumulator with one radix-2 shift-add (mul) or restoring
// shift-subtract (div) step per cycle.
module mdu_shift_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic              mode_div,
  input  logic [2*XLEN-1:0] init,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc
);

  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_nx;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;

  // mul: {hi,lo} with multiplier in lo; div: {remainder, dividend/quotient}
  always_comb begin
    sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd} : '0);
    rem_sh = acc_q[2*XLEN-1:XLEN-1];
    diff   = rem_sh - {1'b0, opnd};
    acc_nx = {sum, acc_q[XLEN-1:1]};
    if (mode_div) begin
      if (!diff[XLEN]) acc_nx = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else             acc_nx = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  acc_q <= '0;
    else if (load) acc_q <= init;
    else if (step) acc_q <= acc_nx;
  end

  assign acc = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M/RV64M iterative multiply/divide unit: FSM, sign handling, special cases.
// Optional macro MDU_EARLY_OUT_EN lets trivial cases skip the iteration loop.
module muldiv_unit
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t state_q, state_nx;
  mdu_op_t    op_q, op_in;
  logic       neg_res_q, neg_rem_q, dz_q, ovf_q, zero_q;
  logic [XLEN-1:0]  a_q, opnd_q;
  logic [CNT_W-1:0] cnt_q;

  logic            accept, div_in, sa, sb, dz_in, ovf_in, zero_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [2*XLEN-1:0] acc, prod;
  logic [XLEN-1:0] quo, rem, res_fix;
`ifdef MDU_EARLY_OUT_EN
  logic special_in;
`endif

  // Decode of the request; only feeds register loads
  always_comb begin
    op_in   = mdu_op_t'(funct3);
    div_in  = op_is_div(op_in);
    sa      = a[XLEN-1] && (op_in inside {MULH, MULHSU, DIV, REM});
    sb      = b[XLEN-1] && (op_in inside {MULH, DIV, REM});
    a_mag   = sa ? -a : a;
    b_mag   = sb ? -b : b;
    dz_in   = div_in && (b == '0);
    ovf_in  = (op_in inside {DIV, REM}) && (a == MIN_NEG) && (b == '1);
    zero_in = !div_in && ((a == '0) || (b == '0));
    accept  = (state_q == IDLE) && start && !kill;
  end

`ifdef MDU_EARLY_OUT_EN
  assign special_in = dz_in || ovf_in || zero_in;
`endif

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef MDU_EARLY_OUT_EN
          state_nx = special_in ? FIXUP : CALC;
`else
          state_nx = CALC;
`endif
        end
      end
      CALC: begin
        if (kill)                                state_nx = IDLE;
        else if (cnt_q == CNT_W'(XLEN - 1))      state_nx = FIXUP;
      end
      FIXUP:   state_nx = kill ? IDLE : DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  mdu_shift_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (accept),
    .step     (state_q == CALC),
    .mode_div (op_is_div(op_q)),
    .init     ({{XLEN{1'b0}}, (div_in ? a_mag : b_mag)}),
    .opnd     (opnd_q),
    .acc      (acc)
  );

  // Sign correction and exact RISC-V special-case overrides
  always_comb begin
    prod = neg_res_q ? -acc : acc;
    quo  = neg_res_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_rem_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    res_fix = '0;
    case (op_q)
      MUL:               res_fix = zero_q ? '0 : prod[XLEN-1:0];
      MULH, MULHSU, MULHU: res_fix = zero_q ? '0 : prod[2*XLEN-1:XLEN];
      DIV, DIVU:         res_fix = dz_q ? '1 : (ovf_q ? MIN_NEG : quo);
      default:           res_fix = dz_q ? a_q : (ovf_q ? '0 : rem);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      op_q      <= MUL;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      a_q       <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      state_q <= state_nx;
      busy    <= (state_nx != IDLE);
      done    <= (state_nx == DONE);
      if (accept) begin
        op_q      <= op_in;
        neg_res_q <= sa ^ sb;
        neg_rem_q <= sa && div_in;
        dz_q      <= dz_in;
        ovf_q     <= ovf_in;
        zero_q    <= zero_in;
        a_q       <= a;
        opnd_q    <= div_in ? b_mag : a_mag;
        cnt_q     <= '0;
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if ((state_q == FIXUP) && (state_nx == DONE)) result <= res_fix;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit (XLEN=32), latency-aware of MDU_EARLY_OUT_EN.
module tb_muldiv_unit;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic            kill = 1'b0;
  logic [2:0]      funct3 = 3'b000;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int n_chk = 0;
  int n_fail = 0;
  logic [XLEN-1:0] sb_q[$];

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .kill    (kill),
    .funct3  (funct3),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op at edge 0, then follow it cycle by cycle until one past done
  task automatic run(input string tag, input logic [2:0] f, input logic [XLEN-1:0] x,
                     input logic [XLEN-1:0] y, input logic [XLEN-1:0] exp, input bit special);
    int lat;
    int done_cyc;
    int done_cnt;
    int busy_bad;
    logic [XLEN-1:0] exp_r;
    lat = 34;
`ifdef MDU_EARLY_OUT_EN
    if (special) lat = 2;
`endif
    done_cyc = -1;
    done_cnt = 0;
    busy_bad = 0;
    @(negedge clk);
    start = 1'b1; funct3 = f; a = x; b = y;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= lat + 1; k++) begin
      if (busy !== (k <= lat)) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = k;
          exp_r = sb_q.pop_front();
          check({tag, " result"}, 64'(result), 64'(exp_r));
        end
      end
      if (k <= lat) begin
        @(posedge clk); #1;
      end
    end
    check({tag, " done_cycle"}, 64'(done_cyc), 64'(lat));
    check({tag, " done_count"}, 64'(done_cnt), 64'd1);
    check({tag, " busy_window"}, 64'(busy_bad), 64'd0);
    if (sb_q.size() > 0) void'(sb_q.pop_front());
  endtask

  initial begin
    int busy_bad;
    int done_seen;

    // Reset state
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", 64'(result), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Multiplies
    run("MUL 7*-3",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
    run("MULH min*min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
    run("MULHU ff*ff",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run("MULHSU ff*ff",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run("MUL 0*5",       3'b000, 32'd0,        32'd5,        32'd0,        1'b1);

    // Divides
    run("DIV -7/2",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
    run("REM -7/2",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
    run("DIVU 100/7",    3'b101, 32'd100,      32'd7,        32'd14,       1'b0);
    run("DIV 5/0",       3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1);
    run("REM 5/0",       3'b110, 32'd5,        32'd0,        32'd5,        1'b1);
    run("REM -5/0",      3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b1);
    run("DIV ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    run("REM ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1);
    run("REMU 100/7",    3'b111, 32'd100,      32'd7,        32'd2,        1'b0);

    // Kill in cycle 10 of DIVU; a start in cycle 5 must be ignored
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    busy_bad = 0;
    done_seen = 0;
    for (int k = 1; k <= 45; k++) begin
      if (busy !== (k <= 10)) busy_bad++;
      if (done === 1'b1) done_seen++;
      start  = (k == 5);
      funct3 = 3'b000; a = 32'd9; b = 32'd9;
      kill   = (k == 10);
      @(posedge clk); #1;
    end
    start = 1'b0; kill = 1'b0;
    check("kill busy_window", 64'(busy_bad), 64'd0);
    check("kill no_done", 64'(done_seen), 64'd0);
    check("kill result_held", 64'(result), 64'd2);

    // Start and kill together in IDLE: nothing accepted
    @(negedge clk);
    start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    check("start+kill busy", 64'(busy), 64'd0);

    // Asynchronous reset in cycle 12 of a MUL
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; a = 32'h1234; b = 32'h10;
    @(posedge clk); #1;
    start = 1'b0;
    done_seen = 0;
    for (int k = 1; k < 12; k++) begin
      if (done === 1'b1) done_seen++;
      @(posedge clk); #1;
    end
    check("pre-reset busy", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async busy", 64'(busy), 64'd0);
    check("async done", 64'(done), 64'd0);
    check("async result", 64'(result), 64'd0);
    check("async no_done", 64'(done_seen), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run("MUL 3*4 after reset", 3'b000, 32'd3, 32'd4, 32'd12, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
